// File: rtl/f_cmp_pipe.sv
// Pipelined FP compare / MIN / MAX unit for single and double operands.
// One operation per cycle; STAGES cycles from accept to ready, with stall and flush.
module f_cmp_pipe #(
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             a_wait,
   input  logic             valid,
   input  logic             opsng,
   input  logic [1:0]       mode,
   input  logic [3:0]       cmp_cond,
   input  logic [63:0]      op_a,
   input  logic [63:0]      op_b,
   input  logic [TAG_W-1:0] tag,
   output logic             busy,
   output logic             ready,
   output logic [TAG_W-1:0] out_tag,
   output logic             result,
   output logic [63:0]      result_val,
   output logic             invalid
);

   localparam int unsigned PD     = (STAGES > 1) ? STAGES - 1 : 1;
   localparam int unsigned EXP_W  = 11;
   localparam int unsigned FRAC_W = 52;

   localparam logic [1:0] MODE_CMP = 2'd0;
   localparam logic [1:0] MODE_MIN = 2'd1;
   localparam logic [1:0] MODE_MAX = 2'd2;

   localparam logic [63:0] QNAN_S = 64'h0000_0000_7FC0_0000;
   localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
      logic              nan;
      logic              snan;
      logic              zero;
   } cls_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [1:0]       mode;
      logic [3:0]       cond;
      logic             sngl;
      logic [63:0]      a;
      logic [63:0]      b;
      logic             sign_a;
      logic             sign_b;
      logic             nan_a;
      logic             nan_b;
      logic             snan_a;
      logic             snan_b;
      logic             zero_a;
      logic             zero_b;
      logic             exp_eq;
      logic             exp_lt;
      logic             frac_eq;
      logic             frac_lt;
   } stage_t;

   typedef struct packed {
      logic        result;
      logic [63:0] val;
      logic        invalid;
   } res_t;

   // Unpack one operand into sign/exp/frac (single widened into the double fields).
   function automatic cls_t classify(input logic sngl, input logic [63:0] x);
      cls_t c;
      logic exp_ones;
      logic frac_msb;
      if (sngl) begin
         c.sign   = x[31];
         c.exp    = EXP_W'(x[30:23]);
         c.frac   = FRAC_W'(x[22:0]);
         exp_ones = &x[30:23];
         frac_msb = x[22];
      end else begin
         c.sign   = x[63];
         c.exp    = x[62:52];
         c.frac   = x[51:0];
         exp_ones = &x[62:52];
         frac_msb = x[51];
      end
      c.nan  = exp_ones & (|c.frac);
      c.snan = c.nan & ~frac_msb;
      c.zero = ~(|c.exp) & ~(|c.frac);
      return c;
   endfunction

   // Final evaluation from the registered classification and magnitude partials.
   function automatic res_t evaluate(input stage_t s);
      res_t        r;
      logic        mag_eq;
      logic        mag_lt;
      logic        mag_gt;
      logic        tot_lt;
      logic        unord;
      logic        both_zero;
      logic        eq;
      logic        lt;
      logic [63:0] qnan;

      mag_eq    = s.exp_eq & s.frac_eq;
      mag_lt    = s.exp_lt | (s.exp_eq & s.frac_lt);
      mag_gt    = ~mag_lt & ~mag_eq;
      unord     = s.nan_a | s.nan_b;
      both_zero = s.zero_a & s.zero_b;
      qnan      = s.sngl ? QNAN_S : QNAN_D;

      // Total sign-magnitude order in which -0 sorts below +0.
      case ({s.sign_a, s.sign_b})
         2'b10:   tot_lt = 1'b1;
         2'b01:   tot_lt = 1'b0;
         2'b00:   tot_lt = mag_lt;
         default: tot_lt = mag_gt;
      endcase

      eq = ~unord & (((s.sign_a == s.sign_b) & mag_eq) | both_zero);
      lt = ~unord & ~eq & tot_lt;

      r = '0;
      case (s.mode)
         MODE_CMP: begin
            r.result  = (s.cond[0] & unord) | (s.cond[1] & eq) | (s.cond[2] & lt);
            r.invalid = unord & (s.cond[3] | s.snan_a | s.snan_b);
         end
         MODE_MIN, MODE_MAX: begin
            if (s.nan_a & s.nan_b)
               r.val = qnan;
            else if (s.nan_a)
               r.val = s.b;
            else if (s.nan_b)
               r.val = s.a;
            else if (s.mode == MODE_MIN)
               r.val = tot_lt ? s.a : s.b;
            else
               r.val = tot_lt ? s.b : s.a;
            r.invalid = s.snan_a | s.snan_b;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   cls_t                cls_a;
   cls_t                cls_b;
   stage_t              s_in;
   stage_t              ev_src;
   res_t                ev;
   stage_t              pipe [PD];
   logic [STAGES-1:0]   vld;
   logic [STAGES-1:0]   vld_nxt;

   // Stage-1 payload: classification plus exponent/fraction compare partials.
   always_comb begin
      cls_a          = classify(opsng, op_a);
      cls_b          = classify(opsng, op_b);
      s_in           = '0;
      s_in.tag       = tag;
      s_in.mode      = mode;
      s_in.cond      = cmp_cond;
      s_in.sngl      = opsng;
      s_in.a         = opsng ? {32'd0, op_a[31:0]} : op_a;
      s_in.b         = opsng ? {32'd0, op_b[31:0]} : op_b;
      s_in.sign_a    = cls_a.sign;
      s_in.sign_b    = cls_b.sign;
      s_in.nan_a     = cls_a.nan;
      s_in.nan_b     = cls_b.nan;
      s_in.snan_a    = cls_a.snan;
      s_in.snan_b    = cls_b.snan;
      s_in.zero_a    = cls_a.zero;
      s_in.zero_b    = cls_b.zero;
      s_in.exp_eq    = (cls_a.exp == cls_b.exp);
      s_in.exp_lt    = (cls_a.exp < cls_b.exp);
      s_in.frac_eq   = (cls_a.frac == cls_b.frac);
      s_in.frac_lt   = (cls_a.frac < cls_b.frac);
   end

   generate
      if (STAGES == 1) begin : g_flat
         assign ev_src = s_in;
      end else begin : g_piped
         assign ev_src = pipe[PD-1];
      end
   endgenerate

   assign ev    = evaluate(ev_src);
   assign ready = vld[STAGES-1];

   // Valid-bit shift; flush beats stall, stall freezes everything.
   always_comb begin
      vld_nxt = vld;
      if (flush) begin
         vld_nxt = '0;
      end else if (!a_wait) begin
         vld_nxt[0] = valid;
         for (int unsigned k = 1; k < STAGES; k++)
            vld_nxt[k] = vld[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         vld        <= '0;
         busy       <= 1'b0;
         out_tag    <= '0;
         result     <= 1'b0;
         result_val <= '0;
         invalid    <= 1'b0;
      end else begin
         vld  <= vld_nxt;
         busy <= |vld_nxt;
         if (!flush && !a_wait) begin
            pipe[0] <= s_in;
            for (int unsigned k = 1; k < PD; k++)
               pipe[k] <= pipe[k-1];
            out_tag    <= ev_src.tag;
            result     <= ev.result;
            result_val <= ev.val;
            invalid    <= ev.invalid;
         end
      end
   end

endmodule
